// File: rtl/cla_word_sequencer_if.sv
// Wide-operand and wide-result valid/ready bundle for cla_word_sequencer.
// CLA_SEQ_OVF_EN adds the out_ovf result flag.
interface cla_word_sequencer_if #(
  parameter int NUM_WORDS = 4
);
  localparam int W = 16 * NUM_WORDS;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef CLA_SEQ_OVF_EN
  logic         out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin,
    output out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_cout
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin,
    input  out_ready,
    output in_ready, out_valid, out_sum,
    output out_cout
  );
`endif
endinterface

// File: rtl/cla_word_sequencer.sv
// Streams wide operands through the 16-bit registered CLA adder, LSW first.
// CLA_SEQ_OVF_EN adds the signed-overflow output out_ovf.
module cla_word_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cla_word_sequencer_if.slave  bus,
  output logic [15:0]          add_a,
  output logic [15:0]          add_b,
  output logic                 add_cin,
  input  logic [15:0]          add_sum,
  input  logic                 add_cout
);
  localparam int KW  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int MSW = NUM_WORDS - 1;
  localparam logic [KW-1:0] K_LAST = KW'(MSW);

  typedef enum logic [1:0] {
    IDLE, RUN, DRAIN, DONE
  } state_t;

  state_t state, state_d;

  logic [KW-1:0]               k;
  logic                        carry_reg;
  logic [NUM_WORDS-1:0][15:0]  a_reg;
  logic [NUM_WORDS-1:0][15:0]  b_reg;
  logic [NUM_WORDS-1:0][15:0]  res;
  logic                        valid_q;
  logic                        cout_q;
  logic                        in_ready_w;
  logic                        accept;
  logic                        last;

  assign in_ready_w    = rst_n && (state == IDLE);
  assign accept        = bus.in_valid && in_ready_w;
  assign last          = (k == K_LAST);
  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = valid_q;
  assign bus.out_sum   = res;
  assign bus.out_cout  = cout_q;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state)
      IDLE:  if (accept) state_d = RUN;
      RUN: begin
        add_a   = a_reg[k];
        add_b   = b_reg[k];
        add_cin = carry_reg;
        if (last) state_d = DRAIN;
      end
      DRAIN: state_d = DONE;
      DONE:  if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // add_sum lags add_a/add_b by one edge, so RUN stores chunk k-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k         <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      res       <= '0;
      valid_q   <= 1'b0;
      cout_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg     <= bus.in_a;
            b_reg     <= bus.in_b;
            carry_reg <= bus.in_cin;
            k         <= '0;
          end
        end
        RUN: begin
          carry_reg <= add_cout;
          if (k != '0) res[k - KW'(1)] <= add_sum;
          if (!last)   k <= k + KW'(1);
        end
        DRAIN: begin
          res[MSW] <= add_sum;
          cout_q   <= carry_reg;
          valid_q  <= 1'b1;
        end
        DONE: begin
          if (bus.out_ready) valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef CLA_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (state == DRAIN) begin
      ovf_q <= (a_reg[MSW][15] == b_reg[MSW][15]) &&
               (add_sum[15] != a_reg[MSW][15]);
    end
  end

  assign bus.out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_word_sequencer.sv
// Self-checking bench for cla_word_sequencer (4-word and 1-word builds).
// Includes a behavioural model of the registered 16-bit adder core.
module tb_cla_word_sequencer;
  localparam int NW = 4;
  localparam int W  = 16 * NW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cla_word_sequencer_if #(.NUM_WORDS(NW)) bus ();
  cla_word_sequencer_if #(.NUM_WORDS(1))  bus1 ();

  logic [15:0] add_a, add_b, add_sum;
  logic        add_cin, add_cout;
  logic [15:0] a1, b1, s1;
  logic        cin1, cout1;

  cla_word_sequencer #(.NUM_WORDS(NW)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  cla_word_sequencer #(.NUM_WORDS(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus1.slave),
    .add_a    (a1),
    .add_b    (b1),
    .add_cin  (cin1),
    .add_sum  (s1),
    .add_cout (cout1)
  );

  // Adder core: registered sum, combinational carry-out.
  logic [16:0] s17, s17_1;
  assign s17   = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);
  assign s17_1 = {1'b0, a1} + {1'b0, b1} + 17'(cin1);
  assign add_cout = s17[16];
  assign cout1    = s17_1[16];
  always @(posedge clk) begin
    add_sum <= s17[15:0];
    s1      <= s17_1[15:0];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W:0] act,
                     input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + (W+1)'(cin);
  endfunction

  function automatic logic carry_into(input logic [W-1:0] a,
                                      input logic [W-1:0] b,
                                      input logic cin, input int i);
    logic [W:0] mask, lo;
    mask = ((W+1)'(1) << (16 * i)) - 1;
    lo   = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(cin);
    return lo[16 * i];
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int stall, input bit poke,
                        input string tag, output logic [W:0] got);
    logic [W:0] r;
    int n;
    r = ref_add(a, b, cin);
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    chk({tag, " in_ready"}, bus.in_ready, 1);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    if (poke) begin
      bus.in_valid = 1'b1;
      bus.in_a     = ~a;
      bus.in_b     = ~b;
      bus.in_cin   = ~cin;
    end
    for (int i = 0; i < NW; i++) begin
      chk({tag, " add_a"}, add_a, a[16*i +: 16]);
      chk({tag, " add_b"}, add_b, b[16*i +: 16]);
      chk({tag, " add_cin"}, add_cin, carry_into(a, b, cin, i));
      if (poke) chk({tag, " busy"}, bus.in_ready, 0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk({tag, " drain_a"}, add_a, 0);
    n = NW;
    while (!bus.out_valid && n < 40) begin
      tick();
      n++;
    end
    chk({tag, " latency"}, n, NW + 1);
    chk({tag, " sum"}, bus.out_sum, r[W-1:0]);
    chk({tag, " cout"}, bus.out_cout, r[W]);
`ifdef CLA_SEQ_OVF_EN
    chk({tag, " ovf"}, bus.out_ovf,
        (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
`endif
    got = {bus.out_cout, bus.out_sum};
    for (int s = 0; s < stall; s++) begin
      tick();
      chk({tag, " hold_v"}, bus.out_valid, 1);
      chk({tag, " hold_s"}, {bus.out_cout, bus.out_sum}, r);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({tag, " v_drop"}, bus.out_valid, 0);
    chk({tag, " rdy_back"}, bus.in_ready, 1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t       tbl[4];
  logic [W:0] got;
  logic [W-1:0] ra, rb;
  int         n;
  int         bad;

  initial begin
    tbl[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h0, 1'b1, 1'b0};
    tbl[1] = '{64'h0001_0002_0003_0004, 64'h0010_0020_0030_0040, 1'b1,
               64'h0011_0022_0033_0045, 1'b0, 1'b0};
    tbl[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0,
               64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1,
               64'h1, 1'b1, 1'b1};

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.in_a      = '0;
    bus1.in_b      = '0;
    bus1.in_cin    = 1'b0;
    bus1.out_ready = 1'b0;
    repeat (3) tick();
    chk("rst in_ready", bus.in_ready, 0);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst out_sum", bus.out_sum, 0);
    chk("rst out_cout", bus.out_cout, 0);
    chk("rst add_a", add_a, 0);
    rst_n = 1'b1;
    tick();
    chk("post-rst in_ready", bus.in_ready, 1);

    for (int i = 0; i < 4; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 0, 1'b0, "tbl", got);
      chk("tbl sum", got[W-1:0], tbl[i].sum);
      chk("tbl cout", got[W], tbl[i].cout);
`ifdef CLA_SEQ_OVF_EN
      chk("tbl ovf", bus.out_ovf, tbl[i].ovf);
`endif
    end

    // Held result, then busy-period in_valid must be ignored.
    run_op(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1,
           3, 1'b1, "stall", got);

    // Abort at k=2 with carry_reg set.
    bus.in_a     = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.in_b     = 64'h1;
    bus.in_cin   = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    chk("abort k2 add_cin", add_cin, 1);
    rst_n = 1'b0;
    #1;
    chk("abort in_ready", bus.in_ready, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("abort rdy_first", bus.in_ready, 1);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.out_valid) bad++;
      tick();
    end
    chk("abort no_valid", bad, 0);
    run_op(64'h5, 64'h3, 1'b0, 0, 1'b0, "after_abort", got);
    chk("after_abort sum", got, 65'h8);

    for (int t = 0; t < 16; t++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (t % 4 == 1) rb = ~ra;
      if (t % 4 == 2) rb = 64'h0;
      run_op(ra, rb, 1'($urandom), int'($urandom_range(0, 2)),
             1'($urandom), "rnd", got);
    end

    // Single-word build: RUN lasts one cycle.
    bus1.in_a     = 16'hFFFF;
    bus1.in_b     = 16'h0001;
    bus1.in_cin   = 1'b1;
    bus1.in_valid = 1'b1;
    chk("nw1 in_ready", bus1.in_ready, 1);
    tick();
    bus1.in_valid = 1'b0;
    chk("nw1 add_a", a1, 16'hFFFF);
    chk("nw1 add_cin", cin1, 1);
    n = 0;
    while (!bus1.out_valid && n < 10) begin
      tick();
      n++;
    end
    chk("nw1 latency", n, 2);
    chk("nw1 sum", bus1.out_sum, 16'h0001);
    chk("nw1 cout", bus1.out_cout, 1);
`ifdef CLA_SEQ_OVF_EN
    chk("nw1 ovf", bus1.out_ovf, 0);
`endif
    bus1.out_ready = 1'b1;
    tick();
    bus1.out_ready = 1'b0;
    chk("nw1 v_drop", bus1.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cla_word_sequencer.md
Name: cla_word_sequencer

Overview:
- Upstream/downstream companion to the 16-bit registered carry-look-ahead adder core.
- Accepts wide operands (NUM_WORDS x 16 bits) over a valid/ready handshake.
- Feeds them to the adder one 16-bit chunk per cycle, LSW first, chaining the adder's carry-out into the next chunk's carry-in.
- Collects the adder's registered sums, then presents the assembled wide sum and final carry over a valid/ready output handshake.

Parameters:
- NUM_WORDS, 4, number of 16-bit chunks per operand; legal range >= 1; total width W = 16*NUM_WORDS.

Ports:
- clk  in  1  rising-edge clock, shared with the adder core
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  wide operands and in_cin valid
- in_ready  out  1  sequencer can accept operands
- in_a  in  W  operand A
- in_b  in  W  operand B
- in_cin  in  1  carry-in to chunk 0
- out_valid  out  1  out_sum/out_cout valid
- out_ready  in  1  consumer accepts result
- out_sum  out  W  wide sum
- out_cout  out  1  carry-out of the most significant chunk
- add_a  out  16  to adder a
- add_b  out  16  to adder b
- add_cin  out  1  to adder cin
- add_sum  in  16  from adder sum; registered inside the adder, one cycle after inputs
- add_cout  in  1  from adder carry_out16; combinational from the current add_a/add_b/add_cin

Behaviour:
- While rst_n is low at a clk edge:
  - state <= IDLE, chunk index k <= 0, carry_reg <= 0.
  - out_valid, out_sum and out_cout <= 0.
  - Operand and result registers <= 0.
  - in_ready reads 0 while rst_n is low; otherwise in_ready = (state == IDLE).
- add_a, add_b and add_cin are 0 in every state except RUN.
- States:
  - IDLE: on in_valid && in_ready, latch in_a, in_b and in_cin; set carry_reg <= in_cin, k <= 0; go to RUN.
  - RUN:
    - Drive add_a = a_reg[16k+15:16k], add_b = b_reg[16k+15:16k], add_cin = carry_reg.
    - Each edge: carry_reg <= add_cout. If k >= 1, res[k-1] <= add_sum (the chunk k-1 result produced by the adder's register).
    - If k == NUM_WORDS-1, go to DRAIN; else k <= k+1.
  - DRAIN: add_sum now holds chunk NUM_WORDS-1. At the edge: res[NUM_WORDS-1] <= add_sum, out_cout <= carry_reg, out_valid <= 1; go to DONE.
  - DONE: out_sum = res, held stable with out_cout while out_valid=1 && out_ready=0. On out_ready: out_valid <= 0, go to IDLE.
- Latency: out_valid rises NUM_WORDS+1 edges after the accepting edge (5 for the default).
- Minimum operation period is NUM_WORDS+3 cycles, because in_ready is low from RUN through DONE.
- in_valid asserted while not ready is ignored; operands are sampled only on the accept edge.
- NUM_WORDS = 1: RUN lasts one cycle, then DRAIN.
- Arithmetic is modulo 2^W; out_cout is the true carry out of bit W-1.
- add_sum is ignored outside RUN (k >= 1) and DRAIN, so stale adder register contents never leak into the result.
- Reset mid-operation aborts the transaction:
  - The partial result is discarded and out_valid does not assert.
  - The first in_ready=1 is the cycle after rst_n returns high.

Optional Feature:
- Macro CLA_SEQ_OVF_EN.
- When defined: adds output out_ovf (1 bit), the two's-complement signed overflow of the W-bit add: (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]).
  - Registered with out_valid; reset 0; held with out_sum.
- When undefined: the port and its logic are absent; behaviour is otherwise identical.

Test Plan:
- a=0xFFFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> out_sum=0x0, out_cout=1. Carry ripples through all four chunks; out_valid at edge 5 after accept.
- a=0x0001_0002_0003_0004, b=0x0010_0020_0030_0040, cin=1 -> out_sum=0x0011_0022_0033_0045, out_cout=0. Check add_a/add_b chunk order 0x0004/0x0040 first, LSW first.
- a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, cin=0 -> out_sum=0x8000_0000_0000_0000, out_cout=0; out_ovf=1 when CLA_SEQ_OVF_EN is defined.
- Result ready, out_ready held 0 for 3 cycles -> out_valid, out_sum and out_cout stable. Handshake on cycle 4, then in_ready=1 on the following cycle; in_valid during RUN is not accepted.
- rst_n low for 1 cycle during RUN k=2 -> no out_valid. Then next op a=0x5, b=0x3, cin=0 -> out_sum=0x8, proving carry_reg was cleared.
- NUM_WORDS=1 build: a=0xFFFF, b=0x0001, cin=1 -> out_sum=0x0001, out_cout=1, out_valid 2 edges after accept.
